// File: rtl/bxn_counter_if.sv
// Signal bundle between the TTC/FMM control side and the bunch-crossing counter.
// The counter takes the slave modport; the TTC/FMM side (or a bench) takes the master modport.
interface bxn_counter_if;
  logic        ttc_bx0;
  logic        ttc_resync;
  logic        ttc_l1a;
  logic        fmm_trig_stop;
  logic        realign_en;
  logic [11:0] bxn_offset;
  logic [11:0] bxn_counter;
  logic        bxn_running;
  logic        bx0_local;
  logic        bx0_sync_err;
  logic [7:0]  sync_err_cnt;
  logic [11:0] l1a_bxn;
  logic        l1a_valid;
  logic [23:0] l1a_cnt;
  logic [15:0] l1a_drop_cnt;

  modport master (
    output ttc_bx0, ttc_resync, ttc_l1a, fmm_trig_stop, realign_en, bxn_offset,
    input  bxn_counter, bxn_running, bx0_local, bx0_sync_err, sync_err_cnt,
           l1a_bxn, l1a_valid, l1a_cnt, l1a_drop_cnt
  );

  modport slave (
    input  ttc_bx0, ttc_resync, ttc_l1a, fmm_trig_stop, realign_en, bxn_offset,
    output bxn_counter, bxn_running, bx0_local, bx0_sync_err, sync_err_cnt,
           l1a_bxn, l1a_valid, l1a_cnt, l1a_drop_cnt
  );
endinterface

// File: rtl/bxn_counter.sv
// Bunch-crossing counter locked to TTC BC0, with BC0 alignment checking and L1A capture.
// state       | meaning
// ST_STARTUP  | first cycle after reset release, loads offset
// ST_WAIT_BX0 | counter parked at offset, waiting for TTC BC0
// ST_RUN      | free-running orbit counter, checks BC0 and accepts L1A
module bxn_counter #(
  parameter int LHC_CYCLE = 3564
) (
  input logic         clock,
  input logic         reset_i,
  bxn_counter_if.slave bus
);
  typedef enum logic [1:0] {ST_STARTUP, ST_WAIT_BX0, ST_RUN} state_t;

  localparam logic [11:0] LP_MAX = 12'(LHC_CYCLE - 1);

  state_t      r_state;
  logic [11:0] r_bxn;
  logic        r_sync_err;
  logic [7:0]  r_sync_cnt;
  logic [11:0] r_l1a_bxn;
  logic        r_l1a_valid;
  logic [23:0] r_l1a_cnt;
  logic [15:0] r_drop_cnt;

  logic [11:0] w_ofs;
  logic [11:0] w_ofs_inc;
  logic [11:0] w_bxn_inc;
  logic        w_at_ofs;
  logic        w_misalign;

  // An offset outside the orbit can never be reached by the counter, so fall back to 0.
  assign w_ofs      = (bus.bxn_offset <= LP_MAX) ? bus.bxn_offset : 12'd0;
  assign w_ofs_inc  = (w_ofs == LP_MAX) ? 12'd0 : w_ofs + 12'd1;
  assign w_bxn_inc  = (r_bxn == LP_MAX) ? 12'd0 : r_bxn + 12'd1;
  assign w_at_ofs   = (r_bxn == w_ofs);
  assign w_misalign = bus.ttc_bx0 ^ w_at_ofs;

  always_ff @(posedge clock) begin
    if (!reset_i) begin
      r_state     <= ST_STARTUP;
      r_bxn       <= '0;
      r_sync_err  <= 1'b0;
      r_sync_cnt  <= '0;
      r_l1a_bxn   <= '0;
      r_l1a_valid <= 1'b0;
      r_l1a_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_l1a_valid <= 1'b0;
      if (bus.ttc_resync) begin
        r_state    <= ST_WAIT_BX0;
        r_bxn      <= w_ofs;
        r_sync_err <= 1'b0;
        r_sync_cnt <= '0;
        r_l1a_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (bus.ttc_l1a) begin
          if (r_state == ST_RUN && !bus.fmm_trig_stop) begin
            r_l1a_bxn   <= r_bxn;
            r_l1a_cnt   <= r_l1a_cnt + 24'd1;
            r_l1a_valid <= 1'b1;
          end else if (r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
        end
        case (r_state)
          ST_STARTUP: begin
            r_state <= ST_WAIT_BX0;
            r_bxn   <= w_ofs;
          end
          ST_WAIT_BX0: begin
            if (bus.ttc_bx0) begin
              r_state <= ST_RUN;
              r_bxn   <= w_ofs_inc;
            end else begin
              r_bxn <= w_ofs;
            end
          end
          ST_RUN: begin
            if (w_misalign) begin
              r_sync_err <= 1'b1;
              if (r_sync_cnt != 8'hFF) r_sync_cnt <= r_sync_cnt + 8'd1;
            end
            if (w_misalign && bus.ttc_bx0 && bus.realign_en) r_bxn <= w_ofs_inc;
            else                                             r_bxn <= w_bxn_inc;
          end
          default: begin
            r_state <= ST_STARTUP;
            r_bxn   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.bxn_counter  = r_bxn;
  assign bus.bxn_running  = (r_state == ST_RUN);
  assign bus.bx0_local    = (r_state == ST_RUN) && w_at_ofs;
  assign bus.bx0_sync_err = r_sync_err;
  assign bus.sync_err_cnt = r_sync_cnt;
  assign bus.l1a_bxn      = r_l1a_bxn;
  assign bus.l1a_valid    = r_l1a_valid;
  assign bus.l1a_cnt      = r_l1a_cnt;
  assign bus.l1a_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_bxn_counter.sv
// Bench for bxn_counter: directed lock/wrap/misalign/L1A/resync scenarios, then random TTC traffic,
// all compared every cycle against an integer-level orbit model.
module tb_bxn_counter;
  localparam int LHC = 3564;

  logic clock = 1'b0;
  logic reset_i = 1'b0;
  bxn_counter_if bif();

  bxn_counter #(.LHC_CYCLE(LHC)) dut (.clock(clock), .reset_i(reset_i), .bus(bif));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit auto_bx0 = 1'b0;

  // model: 0 startup, 1 waiting for BC0, 2 running
  int m_st = 0, m_bxn = 0, m_err = 0, m_scnt = 0, m_l1bxn = 0, m_valid = 0, m_l1cnt = 0, m_drop = 0;

  function automatic int ofs();
    int o;
    o = int'(bif.bxn_offset);
    return (o < LHC) ? o : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    int o;
    bit mis;
    o = ofs();
    if (!reset_i) begin
      m_st = 0; m_bxn = 0; m_err = 0; m_scnt = 0; m_l1bxn = 0; m_valid = 0; m_l1cnt = 0; m_drop = 0;
    end else begin
      m_valid = 0;
      if (bif.ttc_resync) begin
        m_st = 1; m_bxn = o; m_err = 0; m_scnt = 0; m_l1cnt = 0; m_drop = 0;
      end else begin
        if (bif.ttc_l1a) begin
          if (m_st == 2 && !bif.fmm_trig_stop) begin
            m_l1bxn = m_bxn;
            m_l1cnt = (m_l1cnt + 1) % (1 << 24);
            m_valid = 1;
          end else if (m_drop < 65535) m_drop++;
        end
        if (m_st == 0) begin
          m_st = 1; m_bxn = o;
        end else if (m_st == 1) begin
          if (bif.ttc_bx0) begin m_st = 2; m_bxn = (o + 1) % LHC; end
          else m_bxn = o;
        end else begin
          mis = bif.ttc_bx0 != (m_bxn == o);
          if (mis) begin
            m_err = 1;
            if (m_scnt < 255) m_scnt++;
          end
          m_bxn = (mis && bif.ttc_bx0 && bif.realign_en) ? (o + 1) % LHC : (m_bxn + 1) % LHC;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("bxn_counter", int'(bif.bxn_counter), m_bxn);
      chk("bxn_running", int'(bif.bxn_running), int'(m_st == 2));
      chk("bx0_local", int'(bif.bx0_local), int'(m_st == 2 && m_bxn == ofs()));
      chk("bx0_sync_err", int'(bif.bx0_sync_err), m_err);
      chk("sync_err_cnt", int'(bif.sync_err_cnt), m_scnt);
      chk("l1a_bxn", int'(bif.l1a_bxn), m_l1bxn);
      chk("l1a_valid", int'(bif.l1a_valid), m_valid);
      chk("l1a_cnt", int'(bif.l1a_cnt), m_l1cnt);
      chk("l1a_drop_cnt", int'(bif.l1a_drop_cnt), m_drop);
    end
  end

  task automatic cyc();
    if (auto_bx0 && m_st == 2 && m_bxn == ofs()) bif.ttc_bx0 = 1'b1;
    @(posedge clock);
    #1;
    bif.ttc_bx0 = 1'b0;
    bif.ttc_resync = 1'b0;
    bif.ttc_l1a = 1'b0;
  endtask

  task automatic wait_bxn(int target);
    for (int i = 0; i < 4000; i++) begin
      if (m_st == 2 && m_bxn == target) return;
      cyc();
    end
    checks++;
    failures++;
    $display("FAIL wait_bxn timeout target=%0d actual=%0d", target, m_bxn);
  endtask

  function automatic logic [11:0] pick_ofs();
    case ($urandom_range(0, 6))
      0: return 12'd0;
      1: return 12'd160;
      2: return 12'd3563;
      3: return 12'd3564;
      4: return 12'd4000;
      5: return 12'd4095;
      default: return 12'($urandom_range(0, 3563));
    endcase
  endfunction

  initial begin
    bif.ttc_bx0 = 0; bif.ttc_resync = 0; bif.ttc_l1a = 0;
    bif.fmm_trig_stop = 0; bif.realign_en = 0; bif.bxn_offset = 12'd160;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst bxn", int'(bif.bxn_counter), 0);
    chk("rst running", int'(bif.bxn_running), 0);

    reset_i = 1'b1;
    cyc();
    chk("startup bxn", int'(bif.bxn_counter), 160);
    chk("startup running", int'(bif.bxn_running), 0);
    cyc();
    chk("wait bxn", int'(bif.bxn_counter), 160);

    bif.ttc_bx0 = 1'b1;
    cyc();
    chk("lock running", int'(bif.bxn_running), 1);
    chk("lock bxn", int'(bif.bxn_counter), 161);
    auto_bx0 = 1'b1;
    wait_bxn(3563);
    chk("pre wrap", int'(bif.bxn_counter), 3563);
    cyc();
    chk("wrap", int'(bif.bxn_counter), 0);
    wait_bxn(160);
    chk("bx0_local at 160", int'(bif.bx0_local), 1);
    cyc();
    chk("aligned sync_err", int'(bif.bx0_sync_err), 0);

    auto_bx0 = 1'b0;
    wait_bxn(100);
    bif.ttc_bx0 = 1'b1;
    cyc();
    chk("mis sync_err", int'(bif.bx0_sync_err), 1);
    chk("mis cnt1", int'(bif.sync_err_cnt), 1);
    chk("no realign bxn", int'(bif.bxn_counter), 101);
    wait_bxn(160);
    cyc();
    chk("missing bx0 cnt2", int'(bif.sync_err_cnt), 2);
    bif.realign_en = 1'b1;
    wait_bxn(100);
    bif.ttc_bx0 = 1'b1;
    cyc();
    chk("realign bxn", int'(bif.bxn_counter), 161);
    chk("realign cnt3", int'(bif.sync_err_cnt), 3);
    auto_bx0 = 1'b1;

    wait_bxn(1234);
    bif.ttc_l1a = 1'b1;
    cyc();
    chk("l1a bxn", int'(bif.l1a_bxn), 1234);
    chk("l1a valid", int'(bif.l1a_valid), 1);
    chk("l1a cnt", int'(bif.l1a_cnt), 1);
    cyc();
    chk("l1a valid drop", int'(bif.l1a_valid), 0);
    bif.fmm_trig_stop = 1'b1;
    wait_bxn(2000);
    bif.ttc_l1a = 1'b1;
    cyc();
    chk("stop drop cnt", int'(bif.l1a_drop_cnt), 1);
    chk("stop l1a bxn", int'(bif.l1a_bxn), 1234);
    chk("stop no valid", int'(bif.l1a_valid), 0);
    bif.fmm_trig_stop = 1'b0;

    bif.ttc_resync = 1'b1; bif.ttc_bx0 = 1'b1; bif.ttc_l1a = 1'b1;
    cyc();
    chk("resync running", int'(bif.bxn_running), 0);
    chk("resync bxn", int'(bif.bxn_counter), 160);
    chk("resync sync_cnt", int'(bif.sync_err_cnt), 0);
    chk("resync l1a_cnt", int'(bif.l1a_cnt), 0);
    chk("resync drop", int'(bif.l1a_drop_cnt), 0);
    chk("resync valid", int'(bif.l1a_valid), 0);

    bif.ttc_bx0 = 1'b1;
    cyc();
    bif.realign_en = 1'b0;
    auto_bx0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bif.ttc_bx0 = 1'b1;
      cyc();
    end
    chk("sync_cnt saturate", int'(bif.sync_err_cnt), 255);

    reset_i = 1'b0;
    bif.ttc_l1a = 1'b1;
    cyc();
    chk("midrun rst running", int'(bif.bxn_running), 0);
    chk("midrun rst local", int'(bif.bx0_local), 0);
    chk("midrun rst valid", int'(bif.l1a_valid), 0);

    bif.bxn_offset = 12'd4000;
    cyc();
    reset_i = 1'b1;
    cyc();
    chk("oor ofs bxn", int'(bif.bxn_counter), 0);
    bif.ttc_bx0 = 1'b1;
    cyc();
    chk("oor lock bxn", int'(bif.bxn_counter), 1);
    auto_bx0 = 1'b1;
    wait_bxn(0);
    chk("oor bx0_local", int'(bif.bx0_local), 1);

    for (int i = 0; i < 25000; i++) begin
      if ($urandom_range(0, 4999) == 0) begin
        reset_i = 1'b0;
        bif.bxn_offset = pick_ofs();
        cyc();
        cyc();
        reset_i = 1'b1;
      end
      auto_bx0 = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2999) == 0) bif.ttc_resync = 1'b1;
      if ($urandom_range(0, 19) == 0) bif.ttc_l1a = 1'b1;
      if ($urandom_range(0, 499) == 0) bif.ttc_bx0 = 1'b1;
      if (m_st == 1 && $urandom_range(0, 49) == 0) bif.ttc_bx0 = 1'b1;
      if ($urandom_range(0, 199) == 0) bif.fmm_trig_stop = ~bif.fmm_trig_stop;
      if ($urandom_range(0, 499) == 0) bif.realign_en = ~bif.realign_en;
      cyc();
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bxn_counter.md
BXN_COUNTER -- requirements
Module: bxn_counter

Interface
REQ-001 SHALL have parameter LHC_CYCLE, default 3564, the number of bunch crossings per orbit.
REQ-002 SHALL have input clock, 1 bit: the 40 MHz TTC clock; all logic is on its rising edge.
REQ-003 SHALL have input reset_i, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have input ttc_bx0, 1 bit: decoded TTC BC0, one-cycle pulse.
REQ-005 SHALL have input ttc_resync, 1 bit: decoded TTC resync, one-cycle pulse.
REQ-006 SHALL have input ttc_l1a, 1 bit: decoded L1A, one-cycle pulse.
REQ-007 SHALL have input fmm_trig_stop, 1 bit: 1 = triggers stopped (from FMM block).
REQ-008 SHALL have input realign_en, 1 bit: 1 = realign the counter on a misaligned ttc_bx0.
REQ-009 SHALL have input bxn_offset, 12 bits: expected counter value at BC0 (static during run).
REQ-010 SHALL have output bxn_counter, 12 bits: current bunch crossing number.
REQ-011 SHALL have output bxn_running, 1 bit: 1 while in state RUN.
REQ-012 SHALL have output bx0_local, 1 bit: locally generated BC0.
REQ-013 SHALL have output bx0_sync_err, 1 bit: sticky BC0 misalignment flag.
REQ-014 SHALL have output sync_err_cnt, 8 bits: BC0 misalignment count, saturating.
REQ-015 SHALL have output l1a_bxn, 12 bits: bxn_counter latched at the last accepted L1A.
REQ-016 SHALL have output l1a_valid, 1 bit: one-cycle pulse when l1a_bxn updates.
REQ-017 SHALL have output l1a_cnt, 24 bits: accepted L1A count, wrapping.
REQ-018 SHALL have output l1a_drop_cnt, 16 bits: rejected L1A count, saturating.

Function
REQ-019 SHALL implement states STARTUP, WAIT_BX0 and RUN; bxn_running = (state == RUN).
REQ-020 SHALL define the effective offset OFS as bxn_offset when bxn_offset <= LHC_CYCLE-1, and 0 otherwise.
REQ-021 SHALL move from STARTUP to WAIT_BX0 unconditionally one cycle after reset release, loading bxn_counter with OFS.
REQ-022 SHALL hold bxn_counter at OFS in WAIT_BX0.
REQ-023 SHALL, when ttc_bx0 is 1 in WAIT_BX0, enter RUN with bxn_counter = OFS+1 (modulo LHC_CYCLE) on the next cycle.
REQ-024 SHALL, in RUN, increment bxn_counter by 1 every cycle, wrapping from LHC_CYCLE-1 to 0.
REQ-025 SHALL drive bx0_local combinationally from registers as (state == RUN) and (bxn_counter == OFS), with zero latency.
REQ-026 SHALL flag a misalignment in RUN when ttc_bx0 XOR (bxn_counter == OFS) is 1.
REQ-027 SHALL, on a misalignment, set bx0_sync_err on the next cycle and increment sync_err_cnt, saturating at 255.
REQ-028 SHALL, on a misalignment where ttc_bx0 = 1 and realign_en = 1, load bxn_counter with OFS+1 (modulo LHC_CYCLE); otherwise counting continues unchanged.
REQ-029 SHALL accept an L1A when ttc_l1a = 1, state == RUN and fmm_trig_stop = 0.
REQ-030 SHALL, on an accepted L1A, set l1a_bxn to the current bxn_counter, increment l1a_cnt (wrapping 2^24-1 to 0) and pulse l1a_valid, all on the next cycle.
REQ-031 SHALL count any other ttc_l1a pulse in l1a_drop_cnt, saturating at 65535, leaving l1a_bxn unchanged.
REQ-032 SHALL, on ttc_resync in any state: on the next cycle enter WAIT_BX0; set bxn_counter to OFS; clear bx0_sync_err, sync_err_cnt, l1a_cnt and l1a_drop_cnt.
REQ-033 SHALL apply priority: reset over ttc_resync over ttc_bx0 and ttc_l1a; a ttc_bx0 or ttc_l1a coincident with ttc_resync is ignored entirely (not counted, not latched).
REQ-034 SHALL ignore ttc_bx0 in STARTUP.

Reset
REQ-035 SHALL, while reset_i = 0, force state STARTUP.
REQ-036 SHALL, while reset_i = 0, set bxn_counter, l1a_bxn, l1a_cnt, l1a_drop_cnt and sync_err_cnt to 0.
REQ-037 SHALL, while reset_i = 0, set bx0_sync_err and l1a_valid to 0; bx0_local and bxn_running are then 0 as a consequence.
REQ-038 SHALL, when reset_i is asserted mid-RUN, abandon the run within one cycle with no residual pulses.

Verification
REQ-039 SHALL cover lock: bxn_offset = 160, release reset, ttc_bx0 in WAIT_BX0 -> bxn_running = 1, next bxn_counter = 161, bx0_local every 3564 cycles at count 160, bx0_sync_err = 0.
REQ-040 SHALL cover wrap: in RUN, observe 3563 followed by 0.
REQ-041 SHALL cover misalignment: ttc_bx0 at count 100 with realign_en = 0 -> bx0_sync_err = 1 and sync_err_cnt = 1, then sync_err_cnt = 2 at the next count-160 cycle without ttc_bx0; repeat with realign_en = 1 -> next count = 161.
REQ-042 SHALL cover L1A: ttc_l1a at count 1234 with fmm_trig_stop = 0 -> l1a_bxn = 1234, l1a_valid pulse, l1a_cnt = 1; with fmm_trig_stop = 1 -> l1a_drop_cnt = 1 and l1a_bxn unchanged.
REQ-043 SHALL cover resync collision: ttc_resync together with ttc_bx0 and ttc_l1a -> WAIT_BX0, all counters 0, bxn_counter = 160, no l1a_valid.
REQ-044 SHALL cover out-of-range offset: bxn_offset = 4000 -> OFS = 0, bx0_local at count 0.
